fdiv2: RTL and testbench
========================

Name: fdiv2

Overview:
- Floating-point halve unit for the activation vector engine: computes x/2 on one packed float word per transaction.
- Result comes from exponent decrement or subnormal mantissa shift; no multiplier.
- Single-stage registered pipeline with valid/ready handshake, placed between the activation datapath and the downstream vector lanes.
- Default format is bfloat16 (1 sign, 8 exponent, 7 mantissa bits).

Parameters:
- I_EXP, 8, exponent field width in bits.
- I_MNT, 7, stored mantissa (fraction) width in bits.
- I_DATA, I_EXP+I_MNT+1, total word width; must equal I_EXP+I_MNT+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input word valid.
- i_ready  output  1  unit can accept an input this cycle.
- if32  input  I_DATA  input float {sign, exp, mnt}.
- o_valid  output  1  result valid.
- o_ready  input  1  downstream accepts the result.
- of32  output  I_DATA  halved float {sign, exp, mnt}.
- o_inexact  output  1  a nonzero mantissa LSB was shifted out (subnormal path).

Behaviour:
- Reset (rst_n low, asynchronous): o_valid=0, of32=0, o_inexact=0. Outputs stay cleared until the first accepted input after rst_n rises.
- Handshake:
  - i_ready = !o_valid || o_ready (combinational).
  - An input is accepted when i_valid && i_ready.
  - The result register loads on an accepted input; o_valid goes to 1 on the next edge.
  - Latency is 1 cycle; throughput is 1 per cycle when o_ready=1.
  - o_valid && !o_ready holds of32, o_inexact and o_valid stable.
  - When o_valid && o_ready && !i_valid, o_valid clears on the next edge.
  - Simultaneous accept and drain: the new result replaces the old one with no bubble.
- Arithmetic, combinational on if32; s=sign, e=exponent, m=mantissa:
  - Sign is always passed through unchanged.
  - e==0 (zero/subnormal): exponent stays 0; mantissa = {1'b0, m[I_MNT-1:1]}; o_inexact = m[0]. Shifted-out bit is truncated, no rounding. +0 and -0 map to themselves.
  - e==1: exponent becomes 0; mantissa = {1'b1, m[I_MNT-1:1]} (hidden bit becomes the subnormal MSB); o_inexact = m[0].
  - e>=2, including all-ones: exponent = e-1; mantissa unchanged; o_inexact=0.
- The all-ones exponent (Inf/NaN encoding) is decremented like any other by default; see Optional Feature.
- No exceptions are raised and there is no overflow case. A result never has a larger magnitude than its input.
- All arithmetic is width-generic in I_EXP/I_MNT; there are no hard-coded bfloat16 constants.

Optional Feature:
- Macro FDIV2_IEEE_SPECIAL_EN.
- Defined: an input with e == all ones passes through unchanged (Inf stays Inf, NaN stays NaN with its payload), and o_inexact=0.
- Undefined: an all-ones exponent is decremented like a normal number.
- Handshake and latency are identical in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-transfer with o_valid=1 -> o_valid=0 and of32=0 immediately, without waiting for a clock edge.
- Subnormal path, o_ready=1:
  - 0 00000000 1111111 -> 0 00000000 0111111, o_inexact=1, one cycle later.
  - 1 00000000 1111111 -> 1 00000000 0111111.
- Exponent-1 path:
  - 0 00000001 1111111 -> 0 00000000 1111111.
  - 1 00000001 1111110 -> 1 00000000 1111111, o_inexact=0.
- Normal path:
  - 0 00100001 1111111 -> 0 00100000 1111111.
  - 0 01111000 1111111 -> 0 01110111 1111111.
  - 1 00100001 1111111 -> 1 00100000 1111111.
- Max exponent: 0 11111111 1111111 -> 0 11111110 1111111 without the macro; unchanged with FDIV2_IEEE_SPECIAL_EN defined.
- Backpressure:
  - Stream 4 words with o_ready low for 3 cycles -> i_ready=0 while the stall holds and of32 stays stable.
  - No word is lost or duplicated, order is preserved, and back-to-back throughput is 1 per cycle once o_ready=1.

Source files
------------

// File: rtl/fdiv2.sv
// fdiv2: halves one packed float {sign, exp, mnt} per transaction behind a 1-deep valid/ready register.
// Build option FDIV2_IEEE_SPECIAL_EN: all-ones exponents (Inf/NaN) pass through unchanged.
module fdiv2 #(
    parameter int I_EXP  = 8,
    parameter int I_MNT  = 7,
    parameter int I_DATA = I_EXP + I_MNT + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [I_DATA-1:0] if32,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [I_DATA-1:0] of32,
    output logic              o_inexact
);

    localparam logic [I_EXP-1:0] EXP_ONE  = I_EXP'(1);
    localparam logic [I_EXP-1:0] EXP_ONES = '1;

    logic              in_sign;
    logic [I_EXP-1:0]  in_exp;
    logic [I_MNT-1:0]  in_mnt;

    logic [I_EXP-1:0]  res_exp;
    logic [I_MNT-1:0]  res_mnt;
    logic              res_inexact;

    logic              valid_q,   valid_d;
    logic [I_DATA-1:0] data_q,    data_d;
    logic              inexact_q, inexact_d;

    logic              accept;

    assign in_sign = if32[I_DATA-1];
    assign in_exp  = if32[I_DATA-2 -: I_EXP];
    assign in_mnt  = if32[I_MNT-1:0];

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        res_exp     = in_exp - EXP_ONE;
        res_mnt     = in_mnt;
        res_inexact = 1'b0;
        if (in_exp == '0) begin
            res_exp     = '0;
            res_mnt     = in_mnt >> 1;
            res_inexact = in_mnt[0];
        end else if (in_exp == EXP_ONE) begin
            // The hidden bit drops into the subnormal MSB as the value leaves the normal range.
            res_exp              = '0;
            res_mnt              = in_mnt >> 1;
            res_mnt[I_MNT-1]     = 1'b1;
            res_inexact          = in_mnt[0];
        end
`ifdef FDIV2_IEEE_SPECIAL_EN
        else if (in_exp == EXP_ONES) begin
            res_exp = in_exp;
        end
`endif
    end

    assign i_ready = !valid_q || o_ready;
    assign accept  = i_valid && i_ready;

    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        inexact_d = inexact_q;
        if (accept) begin
            valid_d   = 1'b1;
            data_d    = {in_sign, res_exp, res_mnt};
            inexact_d = res_inexact;
        end else if (o_ready) begin
            valid_d   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            inexact_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            inexact_q <= inexact_d;
        end
    end

    assign o_valid   = valid_q;
    assign of32      = data_q;
    assign o_inexact = inexact_q;

    logic unused_ones;
    assign unused_ones = ^EXP_ONES;

endmodule

// File: tb/tb_fdiv2.sv
// Self-checking bench for fdiv2: directed table, randomized stream against a value-level model, backpressure and async reset.
module tb_fdiv2;

    localparam int EXP = 8;
    localparam int MNT = 7;
    localparam int W   = EXP + MNT + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready = 1'b0;
    logic [W-1:0] if32 = '0;
    logic         i_ready;
    logic         o_valid;
    logic [W-1:0] of32;
    logic         o_inexact;

    int errors = 0;
    int checks = 0;

    logic [W:0]   exp_q[$];
    logic         stall_prev = 1'b0;
    logic [W-1:0] hold_of32;
    logic         hold_inex;

    fdiv2 #(.I_EXP(EXP), .I_MNT(MNT), .I_DATA(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(i_ready), .if32(if32),
        .o_valid(o_valid), .o_ready(o_ready), .of32(of32),
        .o_inexact(o_inexact)
    );

    always #5 clk = ~clk;

    // Value-level reference: halving the significand as an integer, {inexact, result}.
    function automatic logic [W:0] model(input logic [W-1:0] x);
        int s, e, m, re, rm, inex;
        s = int'(x[W-1]);
        e = int'(x[W-2 -: EXP]);
        m = int'(x[MNT-1:0]);
        inex = 0;
        if (e == 0) begin
            re = 0; rm = m / 2; inex = m % 2;
        end else if (e == 1) begin
            re = 0; rm = ((1 << MNT) + m) / 2; inex = m % 2;
        end
`ifdef FDIV2_IEEE_SPECIAL_EN
        else if (e == (1 << EXP) - 1) begin
            re = e; rm = m;
        end
`endif
        else begin
            re = e - 1; rm = m;
        end
        return {inex[0], s[0], re[EXP-1:0], rm[MNT-1:0]};
    endfunction

    // One clock of traffic: drive at negedge, score the transfers the coming posedge will perform.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy,
                        output logic acc, output logic drained);
        logic [W:0] e;
        @(negedge clk);
        if (stall_prev) begin
            checks++;
            if (o_valid !== 1'b1 || of32 !== hold_of32 || o_inexact !== hold_inex) begin
                errors++;
                $display("FAIL stall_hold: got v=%b of32=%h inx=%b, want v=1 of32=%h inx=%b",
                         o_valid, of32, o_inexact, hold_of32, hold_inex);
            end
        end
        i_valid = iv; if32 = d; o_ready = ordy;
        #1;
        checks++;
        if (i_ready !== (!o_valid || ordy)) begin
            errors++;
            $display("FAIL i_ready: got %b, want %b", i_ready, !o_valid || ordy);
        end
        drained = o_valid && ordy;
        if (drained) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_output: got of32=%h, want no output", of32);
            end else begin
                e = exp_q.pop_front();
                if ({o_inexact, of32} !== e) begin
                    errors++;
                    $display("FAIL stream_data: got inx=%b of32=%h, want inx=%b of32=%h",
                             o_inexact, of32, e[W], e[W-1:0]);
                end
            end
        end
        acc = iv && i_ready;
        if (acc) exp_q.push_back(model(d));
        stall_prev = o_valid && !ordy;
        hold_of32  = of32;
        hold_inex  = o_inexact;
    endtask

    task automatic drain_all();
        logic a, dr;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b1, a, dr);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d words left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        logic a, dr;
        #3;
        checks++;
        if (o_valid !== 1'b0 || of32 !== '0 || o_inexact !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b of32=%h inx=%b, want 0 0 0", o_valid, of32, o_inexact);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b1, a, dr);
        checks++;
        if (o_valid !== 1'b0 || of32 !== '0 || i_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: got v=%b of32=%h rdy=%b, want 0 0 1", o_valid, of32, i_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] vin [9];
        logic [W-1:0] vout[9];
        logic         vinx[9];
        logic         a, dr;
        vin[0] = 16'b0_00000000_1111111; vout[0] = 16'b0_00000000_0111111; vinx[0] = 1'b1;
        vin[1] = 16'b1_00000000_1111111; vout[1] = 16'b1_00000000_0111111; vinx[1] = 1'b1;
        vin[2] = 16'b0_00000001_1111111; vout[2] = 16'b0_00000000_1111111; vinx[2] = 1'b1;
        vin[3] = 16'b1_00000001_1111110; vout[3] = 16'b1_00000000_1111111; vinx[3] = 1'b0;
        vin[4] = 16'b0_00100001_1111111; vout[4] = 16'b0_00100000_1111111; vinx[4] = 1'b0;
        vin[5] = 16'b0_01111000_1111111; vout[5] = 16'b0_01110111_1111111; vinx[5] = 1'b0;
        vin[6] = 16'b1_00100001_1111111; vout[6] = 16'b1_00100000_1111111; vinx[6] = 1'b0;
        vin[7] = 16'b1_00000000_0000000; vout[7] = 16'b1_00000000_0000000; vinx[7] = 1'b0;
`ifdef FDIV2_IEEE_SPECIAL_EN
        vin[8] = 16'b0_11111111_1111111; vout[8] = 16'b0_11111111_1111111; vinx[8] = 1'b0;
`else
        vin[8] = 16'b0_11111111_1111111; vout[8] = 16'b0_11111110_1111111; vinx[8] = 1'b0;
`endif
        for (int i = 0; i < 9; i++) begin
            step(1'b1, vin[i], 1'b1, a, dr);
            @(posedge clk); #1;
            checks++;
            if (o_valid !== 1'b1 || of32 !== vout[i] || o_inexact !== vinx[i]) begin
                errors++;
                $display("FAIL directed_%0d: got v=%b of32=%h inx=%b, want v=1 of32=%h inx=%b",
                         i, o_valid, of32, o_inexact, vout[i], vinx[i]);
            end
            step(1'b0, '0, 1'b1, a, dr);
        end
        drain_all();
    endtask

    task automatic test_random();
        logic a, dr;
        logic [W-1:0] d;
        for (int i = 0; i < 400; i++) begin
            d = W'($urandom);
            if ($urandom_range(0, 3) == 0) d[W-2 -: EXP] = EXP'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) d[W-2 -: EXP] = '1;
            step(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 3) != 0), a, dr);
        end
        drain_all();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w[4];
        logic a, dr;
        int idx, done_at;
        for (int i = 0; i < 4; i++) w[i] = W'($urandom);
        idx = 0; done_at = -1;
        for (int c = 0; c < 20 && done_at < 0; c++) begin
            step(idx < 4, (idx < 4) ? w[idx] : '0, !(c >= 1 && c <= 3), a, dr);
            if (c >= 1 && c <= 3) begin
                checks++;
                if (i_ready !== 1'b0 || a !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready_c%0d: got rdy=%b acc=%b, want 0 0", c, i_ready, a);
                end
            end
            if (c >= 4 && c <= 6) begin
                checks++;
                if (a !== 1'b1 || dr !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_throughput_c%0d: got acc=%b drain=%b, want 1 1", c, a, dr);
                end
            end
            if (a) idx++;
            if (idx == 4 && exp_q.size() == 0) done_at = c;
        end
        checks++;
        if (done_at != 7) begin
            errors++;
            $display("FAIL bp_finish: got cycle %0d, want 7", done_at);
        end
        drain_all();
    endtask

    task automatic test_back_to_back();
        logic a, dr;
        int gaps;
        gaps = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, W'($urandom), 1'b1, a, dr);
            if (!a || (i > 0 && !dr)) gaps++;
        end
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL back_to_back: got %0d bubbles, want 0", gaps);
        end
        drain_all();
    endtask

    task automatic test_async_reset();
        logic a, dr;
        step(1'b1, 16'b0_00100001_1010101, 1'b0, a, dr);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || of32 !== '0 || o_inexact !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b of32=%h inx=%b, want 0 0 0", o_valid, of32, o_inexact);
        end
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        rst_n = 1'b1;
        step(1'b0, '0, 1'b1, a, dr);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
